// File: rtl/irq_enc_pkg.sv
// Shared constants, FSM state type and helpers for the irq pending encoder.
// The optional lost counter width lives here as well (see IRQ_PENDING_LOST_CNT_EN).
package irq_enc_pkg;

    localparam int N          = 8;
    localparam int IDXW       = $clog2(N);
    localparam int LOST_CNT_W = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic logic [N-1:0] idx2onehot(input logic [IDXW-1:0] idx);
        return N'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_idx_enc.sv
// Combinational priority encoder: reports whether any bit is set and the
// index of the highest set bit (bit N-1 has highest priority).
module prio_idx_enc
    import irq_enc_pkg::*;
(
    input  logic [N-1:0]    vec,
    output logic            any,
    output logic [IDXW-1:0] idx
);

    always_comb begin
        any = |vec;
        idx = '0;
        // Ascending scan so the last (highest) set bit wins.
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = IDXW'(i);
        end
    end

endmodule

// File: rtl/irq_pending_encoder.sv
// Edge-captured pending register with mask, presenting the highest unmasked
// pending index over valid/ready. Define IRQ_PENDING_LOST_CNT_EN for lost_cnt/lost_clr.
module irq_pending_encoder
    import irq_enc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          mask,
    output logic                  irq_valid,
    input  logic                  irq_ready,
    output logic [IDXW-1:0]       irq_idx,
    output logic [N-1:0]          pending,
`ifdef IRQ_PENDING_LOST_CNT_EN
    input  logic                  lost_clr,
    output logic [LOST_CNT_W-1:0] lost_cnt,
`endif
    output logic                  lost
);

    state_t          state;
    logic [N-1:0]    req_q;
    logic [N-1:0]    rise;
    logic [N-1:0]    clr;
    logic [N-1:0]    elig;
    logic            elig_any;
    logic [IDXW-1:0] elig_idx;
    logic            hs;
    logic            lost_nxt;

    assign rise     = req & ~req_q;
    assign hs       = (state == PRESENT) & irq_valid & irq_ready;
    assign clr      = hs ? idx2onehot(irq_idx) : '0;
    assign elig     = pending & mask;
    // A rise on the bit being cleared re-arms it and is not counted as lost.
    assign lost_nxt = en & |(rise & pending & ~clr);

    prio_idx_enc u_enc (
        .vec (elig),
        .any (elig_any),
        .idx (elig_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending   <= '0;
            lost      <= 1'b0;
            irq_valid <= 1'b0;
            irq_idx   <= '0;
            state     <= IDLE;
        end else begin
            req_q   <= req;
            pending <= en ? ((pending & ~clr) | rise) : (pending & ~clr);
            lost    <= lost_nxt;
            case (state)
                IDLE: begin
                    if (en && elig_any) begin
                        irq_idx   <= elig_idx;
                        irq_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        irq_idx   <= '0;
                        irq_valid <= 1'b0;
                    end
                end
                PRESENT: begin
                    // Index is frozen until accepted; mask/en changes are ignored here.
                    if (hs) begin
                        irq_idx   <= '0;
                        irq_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    irq_idx   <= '0;
                    irq_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef IRQ_PENDING_LOST_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt <= '0;
        end else if (lost_clr) begin
            lost_cnt <= '0;
        end else if (lost_nxt && (lost_cnt != {LOST_CNT_W{1'b1}})) begin
            lost_cnt <= lost_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_irq_pending_encoder.sv
// Directed table-driven bench for irq_pending_encoder plus hand-written
// reset and lost-counter sequences.
module tb_irq_pending_encoder;
    import irq_enc_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    req;
    logic [N-1:0]    mask;
    logic            irq_valid;
    logic            irq_ready;
    logic [IDXW-1:0] irq_idx;
    logic [N-1:0]    pending;
    logic            lost;
`ifdef IRQ_PENDING_LOST_CNT_EN
    logic                  lost_clr;
    logic [LOST_CNT_W-1:0] lost_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    irq_pending_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .mask      (mask),
        .irq_valid (irq_valid),
        .irq_ready (irq_ready),
        .irq_idx   (irq_idx),
        .pending   (pending),
`ifdef IRQ_PENDING_LOST_CNT_EN
        .lost_clr  (lost_clr),
        .lost_cnt  (lost_cnt),
`endif
        .lost      (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       en;
        logic       rdy;
        logic       ev;
        logic [2:0] ei;
        logic [7:0] ep;
        logic       el;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [7:0] r, input logic [7:0] m, input logic e,
                                input logic rd, input logic ev, input logic [2:0] ei,
                                input logic [7:0] ep, input logic el);
        vec_t v;
        v.req = r; v.mask = m; v.en = e; v.rdy = rd;
        v.ev = ev; v.ei = ei; v.ep = ep; v.el = el;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; req = '0; mask = 8'hFF; irq_ready = 1'b0;
`ifdef IRQ_PENDING_LOST_CNT_EN
        lost_clr = 1'b0;
`endif
        // Expected state after each clock edge, inputs applied before that edge.
        //            req    mask  en  rdy  v  idx  pend  lost
        vt.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 0));
        vt.push_back(mk(8'h20, 8'hFF, 1, 1, 0, 0, 8'h20, 0)); // single event
        vt.push_back(mk(8'h20, 8'hFF, 1, 1, 1, 5, 8'h20, 0));
        vt.push_back(mk(8'h20, 8'hFF, 1, 1, 0, 0, 8'h00, 0)); // handshake
        vt.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 0));
        vt.push_back(mk(8'h52, 8'hFF, 1, 1, 0, 0, 8'h52, 0)); // bits 6,4,1
        vt.push_back(mk(8'h52, 8'hFF, 1, 1, 1, 6, 8'h52, 0));
        vt.push_back(mk(8'h52, 8'hFF, 1, 1, 0, 0, 8'h12, 0));
        vt.push_back(mk(8'h52, 8'hFF, 1, 1, 1, 4, 8'h12, 0));
        vt.push_back(mk(8'h52, 8'hFF, 1, 1, 0, 0, 8'h02, 0));
        vt.push_back(mk(8'h52, 8'hFF, 1, 1, 1, 1, 8'h02, 0));
        vt.push_back(mk(8'h52, 8'hFF, 1, 1, 0, 0, 8'h00, 0)); // held req: no re-event
        vt.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 0));
        vt.push_back(mk(8'h84, 8'h04, 1, 0, 0, 0, 8'h84, 0)); // mask + stall
        vt.push_back(mk(8'h84, 8'h04, 1, 0, 1, 2, 8'h84, 0));
        vt.push_back(mk(8'h84, 8'h04, 1, 0, 1, 2, 8'h84, 0));
        vt.push_back(mk(8'h84, 8'hFF, 1, 0, 1, 2, 8'h84, 0));
        vt.push_back(mk(8'h84, 8'hFF, 1, 0, 1, 2, 8'h84, 0));
        vt.push_back(mk(8'h84, 8'h00, 0, 0, 1, 2, 8'h84, 0));
        vt.push_back(mk(8'h84, 8'hFF, 1, 1, 0, 0, 8'h80, 0));
        vt.push_back(mk(8'h84, 8'hFF, 1, 1, 1, 7, 8'h80, 0));
        vt.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 0));
        vt.push_back(mk(8'h08, 8'h00, 1, 1, 0, 0, 8'h08, 0)); // masked retention
        vt.push_back(mk(8'h00, 8'h00, 1, 1, 0, 0, 8'h08, 0));
        vt.push_back(mk(8'h00, 8'h00, 1, 1, 0, 0, 8'h08, 0));
        vt.push_back(mk(8'h00, 8'h08, 1, 1, 1, 3, 8'h08, 0));
        vt.push_back(mk(8'h08, 8'h08, 1, 1, 0, 0, 8'h08, 0)); // collision: re-rise wins
        vt.push_back(mk(8'h08, 8'h08, 1, 1, 1, 3, 8'h08, 0));
        vt.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 0));
        vt.push_back(mk(8'h01, 8'hFF, 1, 0, 0, 0, 8'h01, 0)); // lost on bit 0
        vt.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 0, 8'h01, 0));
        vt.push_back(mk(8'h01, 8'hFF, 1, 0, 1, 0, 8'h01, 1));
        vt.push_back(mk(8'h01, 8'hFF, 1, 0, 1, 0, 8'h01, 0));
        vt.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 0, 8'h01, 0));
        vt.push_back(mk(8'h01, 8'hFF, 0, 0, 1, 0, 8'h01, 0)); // en=0: no lost
        vt.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 0));
        vt.push_back(mk(8'h10, 8'hFF, 0, 1, 0, 0, 8'h00, 0)); // en=0: event dropped
        vt.push_back(mk(8'h10, 8'hFF, 1, 1, 0, 0, 8'h00, 0));
        vt.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 0));

        #12;
        chk("reset_valid", int'(irq_valid), 0);
        chk("reset_pending", int'(pending), 0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("idle%0d_valid", c), int'(irq_valid), 0);
            chk($sformatf("idle%0d_idx", c), int'(irq_idx), 0);
            chk($sformatf("idle%0d_pending", c), int'(pending), 0);
        end

        foreach (vt[i]) begin
            req = vt[i].req; mask = vt[i].mask; en = vt[i].en; irq_ready = vt[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), int'(irq_valid), int'(vt[i].ev));
            chk($sformatf("v%0d_idx", i), int'(irq_idx), int'(vt[i].ei));
            chk($sformatf("v%0d_pending", i), int'(pending), int'(vt[i].ep));
            chk($sformatf("v%0d_lost", i), int'(lost), int'(vt[i].el));
        end

`ifdef IRQ_PENDING_LOST_CNT_EN
        chk("lost_cnt_one", int'(lost_cnt), 1);
        lost_clr = 1'b1;
        step();
        lost_clr = 1'b0;
        chk("lost_cnt_clr", int'(lost_cnt), 0);
`endif

        // Asynchronous reset while presenting.
        req = 8'h02; mask = 8'hFF; en = 1'b1; irq_ready = 1'b0;
        step();
        step();
        chk("pre_rst_valid", int'(irq_valid), 1);
        chk("pre_rst_idx", int'(irq_idx), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(irq_valid), 0);
        chk("async_rst_pending", int'(pending), 0);
        chk("async_rst_idx", int'(irq_idx), 0);
        req = 8'h00;
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_valid", int'(irq_valid), 0);
        chk("post_rst_pending", int'(pending), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_pending_encoder.md
Name: irq_pending_encoder

Overview:
- Downstream consumer stage for an 8-line priority encode.
- Captures rising edges on 8 request lines into a pending register and applies a mask.
- Presents the highest-index unmasked pending request as a 3-bit index over a valid/ready handshake.
- Clears the serviced pending bit on acceptance; sits between raw event sources and a sequential service controller.

Parameters:
N, 8, number of request lines (bit N-1 = highest priority)
IDXW, 3, index width, must equal clog2(N)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  capture/present enable
req  input  N  level request lines, rising edges are events
mask  input  N  1 = line eligible for presentation
irq_valid  output  1  index valid
irq_ready  input  1  consumer accepts index
irq_idx  output  IDXW  highest-priority pending index
pending  output  N  current pending register
lost  output  1  one-cycle pulse: event on already-pending line

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. Reset drives req_q, pending, irq_valid, irq_idx and lost to 0, with FSM in IDLE.
- Edge detect: req_q <= req every cycle regardless of en; rise = req & ~req_q.
- Capture: when en=1, pending <= (pending & ~clr) | rise. When en=0, pending <= pending & ~clr.
- Capture vs clear collision: clr is one-hot of irq_idx on handshake. A new rise on the bit being cleared in the same cycle wins, so the bit stays pending.
- lost: asserted for one cycle when en=1 and (rise & pending & ~clr) != 0.
- FSM IDLE:
  - If en=1 and (pending & mask) != 0, register irq_idx = highest set index of (pending & mask), set irq_valid=1, go to PRESENT.
  - Otherwise irq_valid=0 and irq_idx=0.
- FSM PRESENT:
  - irq_idx and irq_valid are held stable until irq_valid & irq_ready.
  - Mask, en or new events do not change the presented index.
  - On handshake: clr = 1<<irq_idx, irq_valid<=0, irq_idx<=0, go to IDLE.
- Throughput: minimum one bubble cycle between consecutive presentations.
- Latency: req sampled high at edge t sets pending after edge t. irq_valid rises after edge t+1 when IDLE and eligible.
- irq_ready while IDLE is ignored.
- Masked pending bits are retained indefinitely and present once unmasked.
- All-zero pending&mask leaves the FSM in IDLE; there is no default index-0 presentation.
- Reset mid-PRESENT: outputs drop asynchronously, and the request is lost from pending.
- A req held high produces exactly one event until it goes low and high again.

Optional Feature:
- IRQ_PENDING_LOST_CNT_EN defined:
  - Adds output lost_cnt [7:0], a saturating count of lost pulses (saturates at 255).
  - Adds input lost_clr [1]: a synchronous clear that takes priority over increment.
  - Reset value is 0.
- Undefined: ports absent; lost pulse only.

Decomposition:
- Package irq_enc_pkg holds:
  - N and IDXW constants;
  - the FSM state typedef {IDLE, PRESENT};
  - the lost-counter width constant.
- One natural sub-module: prio_idx_enc. It is purely combinational and maps an N-bit vector to {any, highest-set index}; it is instantiated once on pending & mask.

Test Plan:
- Reset then req=8'h00, mask=8'hFF -> irq_valid=0, pending=0, irq_idx=0 for 10 cycles.
- Single event and handshake:
  - Stimulus: req[5] 0->1 at edge t, irq_ready=1.
  - Response: pending=8'h20 after t; irq_valid=1, irq_idx=5 after t+1; handshake at t+2 clears pending to 0.
- Priority ordering:
  - Stimulus: req rises on bits 1, 4 and 6 simultaneously; irq_ready=1.
  - Response: presentation order 6, 4, 1, each separated by one idle cycle.
- Masking with stall:
  - Stimulus: pending bits 7 and 2, mask=8'h04, irq_ready=0 for 5 cycles.
  - Response: irq_idx=2 held stable; mask changed to 8'hFF mid-stall still shows 2; after accept, 7 is presented.
- Collision:
  - Stimulus: irq_idx=3 presented; in the handshake cycle req[3] re-rises.
  - Response: pending[3] stays 1, no lost pulse, and 3 is presented again.
- Lost/reset: second rise on pending bit 0 -> lost=1 for one cycle (lost_cnt=1 with macro). rst_n low mid-PRESENT -> irq_valid=0 immediately.
